// File: rtl/fhew_pkg.sv
// Shared definitions for the FHEW coefficient datapath blocks.
package fhew_pkg;

  localparam int Q_DEFAULT = 12289;
  localparam int N_DEFAULT = 512;
  localparam int COEF_W    = 16;

  // Accumulator control states, held in 2 bits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } acc_state_t;

endpackage

// File: rtl/mod_cond_sub.sv
// Conditional subtraction of the modulus: folds [0, 2Q) down to [0, Q).
import fhew_pkg::*;

module mod_cond_sub #(
  parameter int Q = Q_DEFAULT
) (
  input  logic [COEF_W:0]   a,
  output logic [COEF_W-1:0] y
);

  localparam logic [COEF_W:0] Q_VAL = (COEF_W + 1)'(Q);

  // Subtract Q once when the operand reaches it; the result always fits in COEF_W bits.
  always_comb begin
    y = a[COEF_W-1:0];
    if (a >= Q_VAL) begin
      y = COEF_W'(a - Q_VAL);
    end
  end

endmodule

// File: rtl/mod_accumulator.sv
// Streaming mod-Q accumulator over N coefficients with a valid/ready result port.
import fhew_pkg::*;

module mod_accumulator #(
  parameter int Q  = Q_DEFAULT,
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        range_err
);

  localparam logic [COEF_W:0]  TWO_Q     = (COEF_W + 1)'(2 * Q);
  localparam logic [CW-1:0]    LAST_BEAT = CW'(N - 1);

  acc_state_t        state;
  acc_state_t        next_state;
  logic [CW-1:0]     beat_cnt;
  logic              s1_valid;
  logic [COEF_W-1:0] s1_r;
  logic [COEF_W-1:0] acc;
  logic [COEF_W-1:0] out_res;
  logic              out_valid_q;
  logic              range_err_q;

  logic [COEF_W:0]   operand;
  logic [COEF_W-1:0] s1_next;
  logic [COEF_W:0]   sum;
  logic [COEF_W-1:0] acc_next;
  logic              accept;
  logic              last_beat;
  logic              start_go;
  logic              unused_upper;

  // The adder's upper half carries nothing for this block.
  assign unused_upper = ^in_data[31:16];

  assign operand   = {1'b0, in_data[COEF_W-1:0]};
  assign sum       = {1'b0, acc} + {1'b0, s1_r};
  assign accept    = in_valid && (state == ACC);
  assign last_beat = accept && (beat_cnt == LAST_BEAT);
  assign start_go  = start && (state == IDLE);

  mod_cond_sub #(.Q(Q)) u_stage1_sub (
    .a (operand),
    .y (s1_next)
  );

  mod_cond_sub #(.Q(Q)) u_stage2_sub (
    .a (sum),
    .y (acc_next)
  );

  // State register; reset discards any partial accumulation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the state-derived handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (last_beat) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        next_state = OUT;
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Two-stage reduce/accumulate pipeline with beat counting and the sticky range flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt    <= '0;
      s1_valid    <= 1'b0;
      s1_r        <= '0;
      acc         <= '0;
      range_err_q <= 1'b0;
    end else if (start_go) begin
      beat_cnt    <= '0;
      s1_valid    <= 1'b0;
      acc         <= '0;
      range_err_q <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_r     <= s1_next;
        beat_cnt <= beat_cnt + 1'b1;
        if (operand >= TWO_Q) begin
          range_err_q <= 1'b1;
        end
      end
      if (s1_valid) begin
        acc <= acc_next;
      end
    end
  end

  // Result register: captures the settled accumulator one cycle into OUT and holds it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_res     <= '0;
    end else if ((state == OUT) && !out_valid_q) begin
      out_valid_q <= 1'b1;
      out_res     <= acc;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = {16'b0, out_res};
  assign range_err = range_err_q;

endmodule

// File: tb/tb_mod_accumulator.sv
// Randomised and directed bench for mod_accumulator (Q = 12289, N = 4).
module tb_mod_accumulator;

  localparam int Q = 12289;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        range_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int exp_hs = 0;

  // Reference model state: residue of the running sum and the error flag.
  int m_sum = 0;
  bit m_err = 0;
  int m_beats = 0;
  bit pending = 0;
  int last_edge = 0;
  bit prev_valid = 0;
  logic [31:0] prev_data = '0;
  bit expect_idle = 0;
  bit chk_clear = 0;

  mod_accumulator #(.Q(Q), .N(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endfunction

  // Compare process: follows the stream at a transaction level and checks the DUT every cycle.
  always @(negedge clk) begin
    int x;
    if (!resetn) begin
      check_output("rst_in_ready", {31'b0, in_ready}, 0);
      check_output("rst_out_valid", {31'b0, out_valid}, 0);
      check_output("rst_busy", {31'b0, busy}, 0);
      check_output("rst_range_err", {31'b0, range_err}, 0);
      m_sum = 0; m_err = 0; m_beats = 0;
      pending = 0; prev_valid = 0; expect_idle = 0; chk_clear = 0;
    end else begin
      if (chk_clear) begin
        check_output("start_clears_err", {31'b0, range_err}, 0);
        chk_clear = 0;
      end
      if (expect_idle) begin
        check_output("idle_after_hs_busy", {31'b0, busy}, 0);
        check_output("idle_after_hs_valid", {31'b0, out_valid}, 0);
        check_output("data_hold_after_hs", out_data, prev_data);
        expect_idle = 0;
      end
      if (pending && cyc == last_edge + 1)
        check_output("valid_early", {31'b0, out_valid}, 0);
      if (pending && cyc == last_edge + 2) begin
        check_output("valid_latency", {31'b0, out_valid}, 1);
        pending = 0;
      end
      if (out_valid) begin
        check_output("in_ready_in_out", {31'b0, in_ready}, 0);
        check_output("busy_in_out", {31'b0, busy}, 1);
        check_output("range_err_at_out", {31'b0, range_err}, {31'b0, m_err});
        if (!m_err) check_output("result", out_data, m_sum);
        if (prev_valid) check_output("data_stable", out_data, prev_data);
      end
      prev_valid = out_valid;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        hs_count++;
        expect_idle = 1;
        prev_valid = 0;
      end
      if (start && !busy) begin
        m_sum = 0; m_err = 0; m_beats = 0; pending = 0;
        chk_clear = 1;
      end else if (in_valid && in_ready) begin
        x = int'(in_data[15:0]);
        if (x >= 2 * Q) m_err = 1;
        m_sum = (m_sum + (x % Q)) % Q;
        m_beats++;
        if (m_beats == N) begin
          pending = 1;
          last_edge = cyc + 1;
        end
      end
    end
  end

  // Drive one accumulation of four beats, then collect the result with optional backpressure.
  task automatic apply_stimulus(input logic [31:0] v [4], input int gap, input int hold,
                                input bit start_in_out, output logic [31:0] res, output logic err);
    int t;
    res = '0;
    err = 1'b0;
    t = 0;
    while (busy && t < 50) begin @(posedge clk); #1; t++; end
    out_ready = (hold == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = v[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data = $urandom;
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (!out_valid) begin
      check_output("out_valid_timeout", {31'b0, out_valid}, 1);
      return;
    end
    res = out_data;
    err = range_err;
    for (int h = 0; h < hold; h++) begin
      if (start_in_out && h == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_hs++;
  endtask

  initial begin
    logic [31:0] basic [4];
    logic [31:0] wrap [4];
    logic [31:0] masked [4];
    logic [31:0] bad [4];
    logic [31:0] rv [4];
    logic [31:0] res;
    logic err;
    int x;

    basic  = '{32'd100, 32'd12294, 32'd24000, 32'd7};
    wrap   = '{32'd12000, 32'd12000, 32'd12000, 32'd12000};
    masked = '{32'hFFFF_0064, 32'hFFFF_3006, 32'hFFFF_5DC0, 32'hFFFF_0007};
    bad    = '{32'd5, 32'd30000, 32'd6, 32'd7};

    resetn = 1'b0; start = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_output("reset_out_data", out_data, 0);
    check_output("reset_in_ready", {31'b0, in_ready}, 0);
    check_output("reset_busy", {31'b0, busy}, 0);
    #20;
    resetn = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(basic, 0, 0, 0, res, err);
    check_output("basic_sum", res, 11823);
    check_output("basic_range_err", {31'b0, err}, 0);

    apply_stimulus(wrap, 0, 0, 0, res, err);
    check_output("wrap_sum", res, 11133);

    apply_stimulus(basic, 2, 3, 1, res, err);
    check_output("stall_sum", res, 11823);
    @(posedge clk); #1;
    check_output("start_in_out_dropped", {31'b0, busy}, 0);

    apply_stimulus(masked, 0, 0, 0, res, err);
    check_output("masked_sum", res, 11823);

    apply_stimulus(bad, 1, 1, 0, res, err);
    check_output("range_err_set", {31'b0, err}, 1);

    apply_stimulus(basic, 0, 0, 0, res, err);
    check_output("after_err_sum", res, 11823);
    check_output("after_err_clear", {31'b0, err}, 0);

    // Abort mid-run with reset: outputs must clear without a clock edge.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_data = 32'd30000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 32'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("pre_reset_range_err", {31'b0, range_err}, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_output("async_in_ready", {31'b0, in_ready}, 0);
    check_output("async_out_valid", {31'b0, out_valid}, 0);
    check_output("async_busy", {31'b0, busy}, 0);
    check_output("async_range_err", {31'b0, range_err}, 0);
    @(negedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(basic, 0, 0, 0, res, err);
    check_output("post_reset_sum", res, 11823);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) x = $urandom_range(2 * Q, 65535);
        else x = $urandom_range(0, 2 * Q - 1);
        rv[i] = {16'($urandom), 16'(x)};
      end
      apply_stimulus(rv, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), res, err);
    end

    repeat (3) @(posedge clk);
    #1;
    check_output("handshake_count", hs_count, exp_hs);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_accumulator.md
# mod_accumulator

Streaming modular accumulator that sits directly downstream of the 16-bit coefficient adder in the FHEW datapath. It consumes the adder's 32-bit output word, which carries the sum in bits [15:0]. Each value is reduced from [0, 2Q) to [0, Q), and a running sum mod Q is accumulated over a vector of N coefficients. The final residue is presented on a valid/ready output.

## Interface
Parameters:
- Q, 12289: modulus. Requires 2 ≤ Q < 2^15.
- N, 512: coefficients per accumulation. Requires N ≥ 1.
- CW, $clog2(N+1): beat-counter width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a new accumulation. Ignored unless in IDLE.
- in_data  in  32  adder output word. Bits [15:0] are the operand; bits [31:16] are ignored.
- in_valid  in  1  in_data valid this cycle. The upstream controller aligns it with the adder's 1-cycle latency.
- in_ready  out  1  block accepts a beat. Reset value 0.
- out_data  out  32  {16'b0, residue[15:0]}. Reset value 0.
- out_valid  out  1  result available. Reset value 0.
- out_ready  in  1  consumer takes the result.
- busy  out  1  high in every state except IDLE. Reset value 0.
- range_err  out  1  sticky flag: some accepted operand was ≥ 2Q. Reset value 0; cleared on an accepted start.

## Operation
- States: IDLE, ACC, DRAIN, OUT.
- IDLE:
  - On start, clear the accumulator, beat counter, stage-1 valid and range_err, then go to ACC.
  - in_ready = 0 and out_valid = 0.
- ACC:
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready. Each accepted beat increments the counter.
  - On the accepted beat that brings the count to N, go to DRAIN.
  - Gaps in in_valid stall the block with no side effects.
  - start is ignored.
- DRAIN:
  - One cycle. The last stage-1 value is folded into the accumulator.
  - Then go to OUT.
- OUT:
  - out_valid = 1, and out_data holds the residue stable.
  - On out_valid & out_ready, go to IDLE. out_valid drops and out_data keeps its last value.
- Stage 1 (registered):
  - x = in_data[15:0]; r = (x ≥ Q) ? x − Q : x.
  - If x ≥ 2Q, set range_err. r is still x − Q; the final result is then unspecified but must not hang the block.
- Stage 2 (registered):
  - s = acc + r, computed 17 bits wide.
  - acc ← (s ≥ Q) ? s − Q : s.
  - Invariant: acc < Q whenever every operand is < 2Q.
- Reset asserted in any state:
  - Immediately forces IDLE and clears all registers and outputs.
  - A partial accumulation is discarded, with no result and no error.

## Timing
- Throughput: one beat per cycle while in ACC.
- Latency: if the final beat is accepted at edge t, then:
  - the accumulator is final after edge t+1;
  - out_valid is first high in the cycle following edge t+2.
- If out_ready is already high when out_valid rises, the handshake completes at the next edge and the block is in IDLE one cycle later.
- A start pulse during OUT is dropped. The next start is honoured only once the block is in IDLE.
- in_ready is 0 for the whole of DRAIN and OUT. The upstream must not depend on beats being accepted there.
- For N = 1: IDLE → ACC (one beat) → DRAIN → OUT.

## Structure
- Shared package fhew_pkg holds:
  - Q_DEFAULT = 12289, N_DEFAULT = 512, COEF_W = 16;
  - the FSM state enum (IDLE, ACC, DRAIN, OUT), encoded in 2 bits.
- One natural sub-module, mod_cond_sub:
  - combinational, parameter Q;
  - 17-bit input, 16-bit output: y = (a ≥ Q) ? a − Q : a.
  - Instantiated twice: stage 1 and stage 2.
- The FSM, counter and handshake logic live in mod_accumulator.

## Test plan
- Basic sum: Q=12289, N=4.
  - Stimulus: start, then low halves 100, 12294, 24000, 7 on consecutive cycles.
  - Required: out_data = 11823, out_valid three cycles after the last accept, range_err = 0.
- Wrap-around: N=4, four beats of 12000.
  - Required intermediate acc values: 12000, 11711, 11422, 11133.
  - Required: out_data = 11133.
- Stalls and backpressure: same vectors as the basic sum, with 2-cycle in_valid gaps between beats and out_ready held low for 3 cycles.
  - Required: result 11823, out_data stable while stalled, a single handshake, then IDLE.
- Upper-half masking and range error:
  - First run, N=4: in_data upper halves set to 0xFFFF with the basic-sum vectors. Required: result 11823.
  - Second run: a beat of 30000. Required: range_err = 1 and the FSM still reaches OUT.
  - A following start clears range_err to 0.
- Reset and ignored start:
  - Assert resetn = 0 after 2 of 4 beats. Required: in_ready, out_valid, busy and range_err are all 0 with no clock edge needed; the block is in IDLE.
  - A start during OUT is ignored.
  - A fresh run after reset yields 11823.
